// File: rtl/argmax_unit.sv
// rtl/argmax_unit.sv - streaming arg-max over one frame of IEEE-754 single class scores
module argmax_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CLASSES = 10,
  parameter int INDEX_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   out_valid,
  output logic [INDEX_WIDTH-1:0] out_index,
  output logic [DATA_WIDTH-1:0]  out_value,
  input  logic                   out_ack
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_CLASSES - 1);

  state_t                 state, next_state;
  logic [INDEX_WIDTH-1:0] count;
  logic [INDEX_WIDTH-1:0] max_idx;
  logic [DATA_WIDTH-1:0]  max_val;
  logic                   accept;
  logic                   last_accept;
  logic                   in_greater;

  // Strict a > b on raw words: NaN sinks below everything, signed zeros tie.
  function automatic logic fp_greater(input logic [DATA_WIDTH-1:0] a,
                                      input logic [DATA_WIDTH-1:0] b);
    logic a_nan, b_nan, a_zero, b_zero;
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_zero = (a[30:0] == 31'd0);
    b_zero = (b[30:0] == 31'd0);
    if (a_nan)                    fp_greater = 1'b0;
    else if (b_nan)               fp_greater = 1'b1;
    else if (a_zero && b_zero)    fp_greater = 1'b0;
    else if (a[31] != b[31])      fp_greater = b[31];
    else if (!a[31])              fp_greater = (a[30:0] > b[30:0]);
    else                          fp_greater = (a[30:0] < b[30:0]);
  endfunction

  assign in_greater  = fp_greater(in_data, max_val);
  assign accept      = (state == ACCUM) && in_valid && !start;
  assign last_accept = accept && (count == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = ACCUM;
      ACCUM:   if (last_accept) next_state = DONE;
      DONE:    if (out_ack) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      max_idx <= '0;
      max_val <= '0;
    end else if ((state == IDLE || state == ACCUM) && start) begin
      count <= '0;
    end else if (accept) begin
      if (count == '0 || in_greater) begin
        max_val <= in_data;
        max_idx <= count;
      end
      count <= count + 1'b1;
    end
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign out_index = max_idx;
  assign out_value = max_val;

endmodule

// File: tb/tb_argmax_unit.sv
// tb/tb_argmax_unit.sv - directed bench for argmax_unit
module tb_argmax_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic [3:0]  out_index;
  logic [31:0] out_value;
  logic        out_ack;

  int checks = 0;
  int errors = 0;
  logic [31:0] frame [10];

  argmax_unit #(.DATA_WIDTH(32), .NUM_CLASSES(10), .INDEX_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_index(out_index), .out_value(out_value), .out_ack(out_ack)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [31:0] def);
    for (int i = 0; i < 10; i++) frame[i] = def;
  endtask

  // Streams frame[] (optionally preceded by a start pulse), then checks result latency and contents.
  task automatic run_frame(input string tag, input bit do_start, input bit gaps,
                           input logic [3:0] exp_idx);
    if (do_start) begin
      start = 1'b1;
      step();
      start = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) step();
      end
      in_valid = 1'b1;
      in_data  = frame[i];
      step();
    end
    in_valid = 1'b0;
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_index"}, {28'd0, out_index}, {28'd0, exp_idx});
    check({tag, "_value"}, out_value, frame[exp_idx]);
  endtask

  task automatic ack();
    out_ack = 1'b1;
    step();
    out_ack = 1'b0;
    check("ack_clears", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ack = 1'b0;
    step(); step();
    reset = 1'b0;
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_index", {28'd0, out_index}, 32'd0);
    check("rst_out_value", out_value,          32'd0);

    // start -> in_ready next cycle, then back-to-back frame
    fill(32'h3F800000); frame[6] = 32'h41200000;
    start = 1'b1; step(); start = 1'b0;
    check("start_ready", {31'd0, in_ready}, 32'd1);
    run_frame("b2b", 1'b0, 1'b0, 4'd6);
    check("done_ready", {31'd0, in_ready}, 32'd0);
    ack();

    run_frame("gaps", 1'b1, 1'b1, 4'd6);
    ack();

    fill(32'hC0000000); frame[3] = 32'hBF800000;
    run_frame("neg", 1'b1, 1'b0, 4'd3);
    ack();
    frame[9] = 32'h00000001;
    run_frame("denorm", 1'b1, 1'b0, 4'd9);
    ack();

    fill(32'hBF800000); frame[2] = 32'h3F800000; frame[7] = 32'h3F800000;
    run_frame("tie", 1'b1, 1'b0, 4'd2);
    ack();
    fill(32'hBF800000); frame[0] = 32'h80000000; frame[1] = 32'h00000000;
    run_frame("zero", 1'b1, 1'b0, 4'd0);
    ack();

    // NaN is the floor: -Inf beats it, and a later NaN does not displace -Inf
    fill(32'h7FC00000); frame[5] = 32'hFF800000;
    run_frame("nan", 1'b1, 1'b0, 4'd5);
    ack();
    fill(32'hFF800000); frame[0] = 32'h7FC00000;
    run_frame("nan_ninf_tie", 1'b1, 1'b0, 4'd1);
    ack();
    frame[4] = 32'h7F800000;
    run_frame("pinf", 1'b1, 1'b0, 4'd4);

    // withheld ack and start during DONE
    for (int c = 0; c < 20; c++) begin
      step();
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_index", {28'd0, out_index}, 32'd4);
      check("hold_value", out_value, 32'h7F800000);
      check("hold_ready", {31'd0, in_ready}, 32'd0);
    end
    start = 1'b1; step(); start = 1'b0;
    check("done_start_valid", {31'd0, out_valid}, 32'd1);
    check("done_start_index", {28'd0, out_index}, 32'd4);
    step();
    check("done_start_ready", {31'd0, in_ready}, 32'd0);
    ack();

    // abort after 4 accepts, then a full frame without another start
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 32'h42C80000; step();
    end
    in_valid = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    check("abort_ready", {31'd0, in_ready}, 32'd1);
    fill(32'h3F800000); frame[6] = 32'h41200000;
    run_frame("abort", 1'b0, 1'b0, 4'd6);
    ack();

    // simultaneous start and in_valid drops the score
    start = 1'b1; step();
    in_valid = 1'b1; in_data = 32'h42C80000;
    check("simul_ready", {31'd0, in_ready}, 32'd1);
    step();
    start = 1'b0;
    run_frame("simul", 1'b0, 1'b0, 4'd6);
    ack();

    // reset mid-frame after 5 accepts
    fill(32'h40000000);
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 32'h40400000; step();
    end
    reset = 1'b1; step(); reset = 1'b0;
    in_valid = 1'b0;
    check("mrst_in_ready",  {31'd0, in_ready},  32'd0);
    check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_out_index", {28'd0, out_index}, 32'd0);
    check("mrst_out_value", out_value,          32'd0);
    repeat (12) step();
    check("mrst_no_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_idle", {31'd0, in_ready}, 32'd0);

    // ack outside DONE is ignored; a fresh frame still works
    out_ack = 1'b1; step(); out_ack = 1'b0;
    frame[8] = 32'h40400000;
    run_frame("post_rst", 1'b1, 1'b0, 4'd8);
    ack();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
